// File: rtl/rv32i_id.sv
// rv32i_id: RV32I instruction-decode stage.
// Drives the register-file read indices straight from the fetched word and
// forwards same-cycle writeback data. Decodes the immediate and control fields,
// then holds everything in the ID/EX register, which supports stall and flush.
module rv32i_id #(
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        insn_valid,
   input  logic [31:0] insn_in,
   input  logic [31:0] pc_in,
   input  logic        stall,
   input  logic        flush,
   output logic [4:0]  rs1_reg,
   output logic [4:0]  rs2_reg,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        wb_enable,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   output logic        id_valid,
   output logic [31:0] pc_out,
   output logic [6:0]  opcode_out,
   output logic [2:0]  funct3_out,
   output logic        funct7b5_out,
   output logic [4:0]  rd_reg_out,
   output logic        rd_wen_out,
   output logic [31:0] imm_out,
   output logic [31:0] rs1_val_out,
   output logic [31:0] rs2_val_out,
   output logic        illegal_out
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Decoded fields of the current instruction word
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [4:0]  w_rd;
   logic [31:0] w_imm;
   logic        w_f7b5;
   logic        w_writes_rd;
   logic        w_illegal;
   logic        w_rd_wen;

   // Per-operand read index, raw regfile data and resolved operand value
   logic [4:0]  w_src_idx  [2];
   logic [31:0] w_src_data [2];
   logic [31:0] w_src_val  [2];

   // ID/EX pipeline register
   logic        r_valid;
   logic [31:0] r_pc;
   logic [6:0]  r_opcode;
   logic [2:0]  r_funct3;
   logic        r_f7b5;
   logic [4:0]  r_rd;
   logic        r_rd_wen;
   logic [31:0] r_imm;
   logic [31:0] r_rs1_val;
   logic [31:0] r_rs2_val;
   logic        r_illegal;

   // Read indices are pure wiring so the regfile sees them in the same cycle.
   // They are not gated by stall.
   assign rs1_reg = insn_in[19:15];
   assign rs2_reg = insn_in[24:20];

   assign w_opcode = insn_in[6:0];
   assign w_funct3 = insn_in[14:12];
   assign w_rd     = insn_in[11:7];

   assign w_src_idx[0]  = rs1_reg;
   assign w_src_idx[1]  = rs2_reg;
   assign w_src_data[0] = rs1_data;
   assign w_src_data[1] = rs2_data;

   // Operand resolution: x0 always reads as zero; otherwise take writeback data
   // when the same register is being written this cycle.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_operand
         always_comb begin
            w_src_val[gi] = w_src_data[gi];
            if (w_src_idx[gi] == 5'd0) begin
               w_src_val[gi] = 32'd0;
            end else if (BYPASS_EN && wb_enable && (wb_reg == w_src_idx[gi])) begin
               w_src_val[gi] = wb_data;
            end
         end
      end
   endgenerate

   // Opcode classification, immediate format selection and funct7 bit 5 qualification
   always_comb begin
      w_imm       = 32'd0;
      w_f7b5      = 1'b0;
      w_writes_rd = 1'b0;
      w_illegal   = 1'b0;
      case (w_opcode)
         OPC_LUI, OPC_AUIPC: begin
            w_imm       = {insn_in[31:12], 12'b0};
            w_writes_rd = 1'b1;
         end
         OPC_JAL: begin
            w_imm       = {{11{insn_in[31]}}, insn_in[31], insn_in[19:12],
                           insn_in[20], insn_in[30:21], 1'b0};
            w_writes_rd = 1'b1;
         end
         OPC_JALR, OPC_LOAD: begin
            w_imm       = {{20{insn_in[31]}}, insn_in[31:20]};
            w_writes_rd = 1'b1;
         end
         OPC_OPIMM: begin
            w_imm       = {{20{insn_in[31]}}, insn_in[31:20]};
            w_writes_rd = 1'b1;
            // Only the shift-right group uses bit 30 to pick logical vs arithmetic
            w_f7b5      = (w_funct3 == 3'b101) ? insn_in[30] : 1'b0;
         end
         OPC_OP: begin
            w_writes_rd = 1'b1;
            w_f7b5      = insn_in[30];
         end
         OPC_BRANCH: begin
            w_imm = {{19{insn_in[31]}}, insn_in[31], insn_in[7],
                     insn_in[30:25], insn_in[11:8], 1'b0};
         end
         OPC_STORE: begin
            w_imm = {{20{insn_in[31]}}, insn_in[31:25], insn_in[11:7]};
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   // Writes to x0 and invalid slots never request a register write
   assign w_rd_wen = w_writes_rd && insn_valid && (w_rd != 5'd0);

   // ID/EX register update with priority reset > flush > stall > load
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid   <= 1'b0;
         r_pc      <= 32'd0;
         r_opcode  <= 7'd0;
         r_funct3  <= 3'd0;
         r_f7b5    <= 1'b0;
         r_rd      <= 5'd0;
         r_rd_wen  <= 1'b0;
         r_imm     <= 32'd0;
         r_rs1_val <= 32'd0;
         r_rs2_val <= 32'd0;
         r_illegal <= 1'b0;
      end else if (flush) begin
         // Bubble: kill the side-effect bits, leave the data fields as they were
         r_valid   <= 1'b0;
         r_rd_wen  <= 1'b0;
         r_illegal <= 1'b0;
      end else if (!stall) begin
         r_valid   <= insn_valid;
         r_pc      <= pc_in;
         r_opcode  <= w_opcode;
         r_funct3  <= w_funct3;
         r_f7b5    <= w_f7b5;
         r_rd      <= w_rd;
         r_rd_wen  <= w_rd_wen;
         r_imm     <= w_imm;
         r_rs1_val <= w_src_val[0];
         r_rs2_val <= w_src_val[1];
         r_illegal <= w_illegal;
      end
   end

   assign id_valid     = r_valid;
   assign pc_out       = r_pc;
   assign opcode_out   = r_opcode;
   assign funct3_out   = r_funct3;
   assign funct7b5_out = r_f7b5;
   assign rd_reg_out   = r_rd;
   assign rd_wen_out   = r_rd_wen;
   assign imm_out      = r_imm;
   assign rs1_val_out  = r_rs1_val;
   assign rs2_val_out  = r_rs2_val;
   assign illegal_out  = r_illegal;

endmodule

// File: tb/tb_rv32i_id.sv
// tb_rv32i_id: directed checks of the rv32i_id decode stage.
// Each step drives one cycle of inputs and queues the ID/EX contents expected
// after the next edge; the queue is popped and compared once that edge is past.
module tb_rv32i_id;

   logic        clk = 1'b0;
   logic        reset;
   logic        insn_valid;
   logic [31:0] insn_in;
   logic [31:0] pc_in;
   logic        stall;
   logic        flush;
   logic [4:0]  rs1_reg;
   logic [4:0]  rs2_reg;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        wb_enable;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        id_valid;
   logic [31:0] pc_out;
   logic [6:0]  opcode_out;
   logic [2:0]  funct3_out;
   logic        funct7b5_out;
   logic [4:0]  rd_reg_out;
   logic        rd_wen_out;
   logic [31:0] imm_out;
   logic [31:0] rs1_val_out;
   logic [31:0] rs2_val_out;
   logic        illegal_out;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        f7b5;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] imm;
      logic [31:0] rs1v;
      logic [31:0] rs2v;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   exp_t bubble;
   int   checks = 0;
   int   errors = 0;

   rv32i_id #(.BYPASS_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .insn_valid(insn_valid), .insn_in(insn_in),
      .pc_in(pc_in), .stall(stall), .flush(flush),
      .rs1_reg(rs1_reg), .rs2_reg(rs2_reg),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
      .id_valid(id_valid), .pc_out(pc_out), .opcode_out(opcode_out),
      .funct3_out(funct3_out), .funct7b5_out(funct7b5_out),
      .rd_reg_out(rd_reg_out), .rd_wen_out(rd_wen_out), .imm_out(imm_out),
      .rs1_val_out(rs1_val_out), .rs2_val_out(rs2_val_out),
      .illegal_out(illegal_out)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic v, input logic [31:0] pc,
                               input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic [4:0] rd,
                               input logic wen, input logic [31:0] imm,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic ill);
      exp_t e;
      e.valid = v;  e.pc = pc;   e.opcode = op; e.funct3 = f3; e.f7b5 = f7;
      e.rd = rd;    e.wen = wen; e.imm = imm;   e.rs1v = r1;   e.rs2v = r2;
      e.ill = ill;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One cycle: drive at negedge, check comb indices, push expectation, pop after the edge
   task automatic step(input string name, input logic rst, input logic v,
                       input logic [31:0] insn, input logic [31:0] pc,
                       input logic st, input logic fl,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input exp_t e);
      exp_t got;
      @(negedge clk);
      reset = rst; insn_valid = v; insn_in = insn; pc_in = pc;
      stall = st; flush = fl; rs1_data = d1; rs2_data = d2;
      wb_enable = we; wb_reg = wr; wb_data = wd;
      exp_q.push_back(e);
      #1;
      check({name, ".rs1_reg"}, {27'd0, rs1_reg}, {27'd0, insn[19:15]});
      check({name, ".rs2_reg"}, {27'd0, rs2_reg}, {27'd0, insn[24:20]});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty observed=0 expected=1", name);
      end else begin
         got = exp_q.pop_front();
         check({name, ".id_valid"}, {31'd0, id_valid},     {31'd0, got.valid});
         check({name, ".pc"},       pc_out,                got.pc);
         check({name, ".opcode"},   {25'd0, opcode_out},   {25'd0, got.opcode});
         check({name, ".funct3"},   {29'd0, funct3_out},   {29'd0, got.funct3});
         check({name, ".f7b5"},     {31'd0, funct7b5_out}, {31'd0, got.f7b5});
         check({name, ".rd"},       {27'd0, rd_reg_out},   {27'd0, got.rd});
         check({name, ".rd_wen"},   {31'd0, rd_wen_out},   {31'd0, got.wen});
         check({name, ".imm"},      imm_out,               got.imm);
         check({name, ".rs1_val"},  rs1_val_out,           got.rs1v);
         check({name, ".rs2_val"},  rs2_val_out,           got.rs2v);
         check({name, ".illegal"},  {31'd0, illegal_out},  {31'd0, got.ill});
         last_exp = got;
         $display("step %-12s pc=%h imm=%h rs1v=%h rs2v=%h valid=%0b wen=%0b ill=%0b",
                  name, pc_out, imm_out, rs1_val_out, rs2_val_out,
                  id_valid, rd_wen_out, illegal_out);
      end
   endtask

   initial begin
      exp_t zero;
      zero = '0;
      reset = 1'b1; insn_valid = 1'b0; insn_in = '0; pc_in = '0; stall = 1'b0;
      flush = 1'b0; rs1_data = '0; rs2_data = '0; wb_enable = 1'b0; wb_reg = '0;
      wb_data = '0;

      // Reset with random inputs on the pins
      for (int i = 0; i < 2; i++) begin
         step("reset", 1'b1, 1'(  $urandom_range(0, 1)), $urandom, $urandom,
              1'(  $urandom_range(0, 1)), 1'(  $urandom_range(0, 1)), $urandom, $urandom,
              1'(  $urandom_range(0, 1)), 5'(  $urandom_range(0, 31)), $urandom, zero);
      end

      // addi x11,x10,10 with x10=0x25; rs2 field is also 10 and reads raw data
      step("addi", 0, 1, 32'h00A50593, 32'h40, 0, 0, 32'h25, 32'h77, 0, 5'd0, 32'h0,
           mk(1, 32'h40, 7'h13, 3'd0, 0, 5'd11, 1, 32'd10, 32'h25, 32'h77, 0));
      // Writeback to x10 in the same cycle overrides stale regfile data
      step("bypass", 0, 1, 32'h00A50593, 32'h44, 0, 0, 32'h0, 32'h0, 1, 5'd10, 32'h25,
           mk(1, 32'h44, 7'h13, 3'd0, 0, 5'd11, 1, 32'd10, 32'h25, 32'h25, 0));
      // Writeback enabled but to x0: no forwarding, raw data passes
      step("wb_x0", 0, 1, 32'h00A50593, 32'h48, 0, 0, 32'h12, 32'h34, 1, 5'd0, 32'h99,
           mk(1, 32'h48, 7'h13, 3'd0, 0, 5'd11, 1, 32'd10, 32'h12, 32'h34, 0));
      // addi x11,x0,10: x0 operand forced to zero despite junk regfile data
      step("rs1_x0", 0, 1, 32'h00A00593, 32'h4C, 0, 0, 32'h55, 32'h33, 1, 5'd0, 32'h99,
           mk(1, 32'h4C, 7'h13, 3'd0, 0, 5'd11, 1, 32'd10, 32'h0, 32'h33, 0));
      // beq x0,x0,-4
      step("beq", 0, 1, 32'hFE000EE3, 32'h50, 0, 0, 32'hDEAD, 32'hBEEF, 0, 5'd0, 32'h0,
           mk(1, 32'h50, 7'h63, 3'd0, 0, 5'd29, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 0));
      // lui x31,0
      step("lui", 0, 1, 32'h00000FB7, 32'h54, 0, 0, 32'h1, 32'h2, 0, 5'd0, 32'h0,
           mk(1, 32'h54, 7'h37, 3'd0, 0, 5'd31, 1, 32'h0, 32'h0, 32'h0, 0));
      // srai x5,x6,3: bit 30 kept for the right-shift group
      step("srai", 0, 1, 32'h40335293, 32'h58, 0, 0, 32'h66, 32'h3, 0, 5'd0, 32'h0,
           mk(1, 32'h58, 7'h13, 3'd5, 1, 5'd5, 1, 32'h403, 32'h66, 32'h3, 0));
      // sw x2,8(x1)
      step("sw", 0, 1, 32'h0020A423, 32'h5C, 0, 0, 32'h11, 32'h22, 0, 5'd0, 32'h0,
           mk(1, 32'h5C, 7'h23, 3'd2, 0, 5'd8, 0, 32'd8, 32'h11, 32'h22, 0));
      // jal x1,-4
      step("jal", 0, 1, 32'hFFDFF0EF, 32'h60, 0, 0, 32'hA1, 32'hA2, 0, 5'd0, 32'h0,
           mk(1, 32'h60, 7'h6F, 3'd7, 0, 5'd1, 1, 32'hFFFFFFFC, 32'hA1, 32'hA2, 0));
      // auipc x10,0x12345
      step("auipc", 0, 1, 32'h12345517, 32'h64, 0, 0, 32'hB1, 32'hB2, 0, 5'd0, 32'h0,
           mk(1, 32'h64, 7'h17, 3'd5, 0, 5'd10, 1, 32'h12345000, 32'hB1, 32'hB2, 0));
      // Invalid slot: fields decode, but no valid and no register write
      step("not_valid", 0, 0, 32'h00A50593, 32'h68, 0, 0, 32'h5, 32'h6, 0, 5'd0, 32'h0,
           mk(0, 32'h68, 7'h13, 3'd0, 0, 5'd11, 0, 32'd10, 32'h5, 32'h6, 0));
      // Illegal opcode
      step("illegal", 0, 1, 32'hFFFFFFFF, 32'h6C, 0, 0, 32'h1, 32'h2, 0, 5'd0, 32'h0,
           mk(1, 32'h6C, 7'h7F, 3'd7, 0, 5'd31, 0, 32'h0, 32'h1, 32'h2, 1));
      // add x0,x1,x2: rd=x0 so no write
      step("add_x0", 0, 1, 32'h00208033, 32'h70, 0, 0, 32'h7, 32'h8, 0, 5'd0, 32'h0,
           mk(1, 32'h70, 7'h33, 3'd0, 0, 5'd0, 0, 32'h0, 32'h7, 32'h8, 0));

      // Load pc=0x100 (add x3,x1,x2), then stall three cycles presenting sub at 0x104
      step("load100", 0, 1, 32'h002081B3, 32'h100, 0, 0, 32'h11, 32'h22, 0, 5'd0, 32'h0,
           mk(1, 32'h100, 7'h33, 3'd0, 0, 5'd3, 1, 32'h0, 32'h11, 32'h22, 0));
      for (int i = 0; i < 3; i++) begin
         step("stall", 0, 1, 32'h407302B3, 32'h104, 1, 0, 32'h99, 32'h98, 1, 5'd6, 32'h97,
              last_exp);
      end
      // Flush together with stall: bubble, data fields held
      bubble = last_exp;
      bubble.valid = 1'b0; bubble.wen = 1'b0; bubble.ill = 1'b0;
      step("flush_stall", 0, 1, 32'h407302B3, 32'h104, 1, 1, 32'h99, 32'h98, 0, 5'd0, 32'h0,
           bubble);
      // Release: sub x5,x6,x7 loads, bit 30 set for OP
      step("sub", 0, 1, 32'h407302B3, 32'h104, 0, 0, 32'h66, 32'h77, 0, 5'd0, 32'h0,
           mk(1, 32'h104, 7'h33, 3'd0, 1, 5'd5, 1, 32'h0, 32'h66, 32'h77, 0));
      // Illegal, then flush clears the illegal flag
      step("illegal2", 0, 1, 32'hFFFFFFFF, 32'h108, 0, 0, 32'h1, 32'h2, 0, 5'd0, 32'h0,
           mk(1, 32'h108, 7'h7F, 3'd7, 0, 5'd31, 0, 32'h0, 32'h1, 32'h2, 1));
      bubble = last_exp;
      bubble.valid = 1'b0; bubble.wen = 1'b0; bubble.ill = 1'b0;
      step("flush", 0, 1, 32'h00A50593, 32'h10C, 0, 1, 32'h3, 32'h4, 0, 5'd0, 32'h0,
           bubble);
      // Reset while stalled wins over stall
      step("lui2", 0, 1, 32'h00000FB7, 32'h110, 0, 0, 32'h1, 32'h2, 0, 5'd0, 32'h0,
           mk(1, 32'h110, 7'h37, 3'd0, 0, 5'd31, 1, 32'h0, 32'h0, 32'h0, 0));
      step("rst_stall", 1, 1, 32'h00A50593, 32'h114, 1, 0, 32'h3, 32'h4, 0, 5'd0, 32'h0,
           zero);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
